rtc_field_sequencer: RTL and testbench
======================================

Name: rtc_field_sequencer

Overview:
- Generalised RTC register-sequencing engine; replaces the fixed three-state seconds/minutes/hours walker.
- On a start pulse it walks N_FIELDS register addresses and issues one bus transaction per field (read or write) to the downstream RTC bus controller.
- Read data is collected in a shadow buffer and committed to the time outputs atomically; a per-transaction timeout is included.
- Sits between the clock/alarm control logic and the RTC bus controller.

Parameters:
- N_FIELDS, 3, number of RTC registers per sweep (1..8).
- DATA_W, 8, width of one field (BCD byte).
- ADDR_W, 8, RTC register address width.
- ADDR_LIST, {8'h23,8'h22,8'h21}, packed N_FIELDS*ADDR_W addresses; field i uses slice i (field 0 = seconds 0x21).
- TIMEOUT_CYC, 255, max cycles to wait for bus_ack per transaction (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle sweep request; ignored while busy
- mode  in  1  sampled with start: 0 = read sweep, 1 = write sweep
- wr_fields  in  N_FIELDS*DATA_W  write data, sampled with start; field i at slice i
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse at sweep end (success or abort)
- err  out  1  timeout flag; set with the aborting done, cleared on next accepted start
- rd_fields  out  N_FIELDS*DATA_W  committed read data, field i at slice i
- bus_req  out  1  transaction request, held until ack or timeout
- bus_wr  out  1  1 = write transaction; valid while bus_req
- bus_addr  out  ADDR_W  register address; valid while bus_req
- bus_wdata  out  DATA_W  write data; valid while bus_req && bus_wr
- bus_ack  in  1  one-cycle completion strobe from bus controller
- bus_rdata  in  DATA_W  read data, valid in the cycle bus_ack is high

Behaviour:
- Reset (async): state IDLE; busy, done, err, bus_req, bus_wr = 0; bus_addr, bus_wdata, rd_fields, shadow, index, timeout count = 0.
- All outputs are registered; the next-state logic assigns defaults that hold current values (no zeroing of data registers).
- States:
  - IDLE: on start, latch mode and wr_fields, index = 0, err = 0, busy = 1, go to REQ.
  - REQ: assert bus_req with addr/wdata/wr for the current index; clear the timeout counter; go to WAIT.
  - WAIT: bus_req stays high.
    - bus_ack = 1: drop bus_req; in read mode capture bus_rdata into shadow[index]; go to NEXT.
    - Counter reaches TIMEOUT_CYC with no ack: drop bus_req, set err, go to DONE.
  - NEXT: if index == N_FIELDS-1 go to DONE; else increment index and go to REQ.
  - DONE: done = 1 for one cycle, busy = 0, go to IDLE.
    - Commit shadow to rd_fields in this cycle only if mode = read and err = 0.
    - Write sweeps and aborted sweeps leave rd_fields unchanged.
- Latency: start at cycle T gives bus_req high at T+2. With an immediate ack, each field takes 3 cycles. done pulses at T+1+3*N_FIELDS+1.
- bus_req is low for at least one cycle between consecutive transactions.
- bus_ack outside WAIT is ignored.
- start while busy is ignored and does not queue.
- start coincident with the DONE cycle is ignored; start is accepted from IDLE only.
- Reset mid-sweep: immediate return to IDLE; rd_fields = 0; no done pulse.
- An ack arriving in the same cycle the counter reaches TIMEOUT_CYC counts as an ack; the ack wins.
- Index width is clog2(N_FIELDS), minimum 1. The index never wraps because the sweep ends at N_FIELDS-1.

Decomposition:
- Shared package rtc_pkg holds:
  - State enum (IDLE, REQ, WAIT, NEXT, DONE).
  - Address constants RTC_ADDR_SEG = 8'h21, RTC_ADDR_MIN = 8'h22, RTC_ADDR_HOR = 8'h23.
  - The default ADDR_LIST built from those constants.
- One sub-module, rtc_timeout_counter: clear, enable, terminal-count output, parameter TIMEOUT_CYC.

Test Plan:
- Read sweep with defaults; model acks 2 cycles after req, returning 0x45, 0x30, 0x12. Required response: bus_addr sequence 0x21, 0x22, 0x23; rd_fields = {0x12,0x30,0x45}; one done pulse; err = 0.
- Write sweep, wr_fields = {0x09,0x15,0x00}, immediate ack. Required response: bus_wr = 1 and bus_wdata 0x00, 0x15, 0x09 in address order; rd_fields unchanged; done at T+11.
- TIMEOUT_CYC = 4, no ack on field 1. Required response: bus_req drops after 4 WAIT cycles; done and err = 1; rd_fields keeps its previous value; field 2 is never requested.
- start pulsed every cycle during a sweep. Required response: exactly one sweep and one done; a start pulse one cycle after done launches a new sweep.
- Reset asserted while in WAIT of field 1. Required response: all outputs 0 asynchronously; no done pulse; a fresh start begins again at address 0x21.
- N_FIELDS = 1, ADDR_LIST = 8'h40. Required response: single transaction; done at T+5 with an immediate ack; ack in the same cycle as timeout terminal count gives err = 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and register-map constants for the RTC field sequencer.
package rtc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StNext,
        StDone
    } rtc_state_e;

    localparam logic [7:0] RTC_ADDR_SEG = 8'h21;
    localparam logic [7:0] RTC_ADDR_MIN = 8'h22;
    localparam logic [7:0] RTC_ADDR_HOR = 8'h23;

    // Field 0 sits in the lowest slice: seconds, minutes, hours.
    localparam logic [23:0] RTC_ADDR_LIST_DFLT = {RTC_ADDR_HOR, RTC_ADDR_MIN, RTC_ADDR_SEG};

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtc_timeout_counter.sv
// Per-transaction wait counter; tc_o flags the final permitted wait cycle.
module rtc_timeout_counter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_field_sequencer.sv
// Walks N_FIELDS RTC registers, one bus transaction each, and commits read data atomically.
module rtc_field_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned N_FIELDS = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter logic [N_FIELDS*ADDR_W-1:0] ADDR_LIST = RTC_ADDR_LIST_DFLT,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic [N_FIELDS*DATA_W-1:0] wr_fields,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [N_FIELDS*DATA_W-1:0] rd_fields,
    output logic                       bus_req,
    output logic                       bus_wr,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [DATA_W-1:0]          bus_wdata,
    input  logic                       bus_ack,
    input  logic [DATA_W-1:0]          bus_rdata
);

    localparam int unsigned IdxW = idx_width(N_FIELDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_FIELDS - 1);

    rtc_state_e                state_q;
    logic [IdxW-1:0]           idx_q;
    logic                      mode_q;
    logic                      abort_q;
    logic [N_FIELDS*DATA_W-1:0] wr_q;
    logic [N_FIELDS*DATA_W-1:0] shadow_q;
    logic [N_FIELDS*DATA_W-1:0] rd_q;
    logic                      busy_q, done_q, err_q;
    logic                      bus_req_q, bus_wr_q;
    logic [ADDR_W-1:0]         bus_addr_q;
    logic [DATA_W-1:0]         bus_wdata_q;
    logic                      tmo_clr, tmo_en, tmo_hit;

    assign tmo_clr = (state_q == StReq);
    assign tmo_en  = (state_q == StWait);

    rtc_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk  (clk),
        .reset(reset),
        .clr_i(tmo_clr),
        .en_i (tmo_en),
        .tc_o (tmo_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            abort_q     <= 1'b0;
            wr_q        <= '0;
            shadow_q    <= '0;
            rd_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q  <= mode;
                        wr_q    <= wr_fields;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    bus_req_q   <= 1'b1;
                    bus_wr_q    <= mode_q;
                    bus_addr_q  <= ADDR_LIST[idx_q*ADDR_W +: ADDR_W];
                    bus_wdata_q <= wr_q[idx_q*DATA_W +: DATA_W];
                    state_q     <= StWait;
                end
                StWait: begin
                    // An ack in the terminal-count cycle still completes the transaction.
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        if (!mode_q) begin
                            shadow_q[idx_q*DATA_W +: DATA_W] <= bus_rdata;
                        end
                        state_q <= StNext;
                    end else if (tmo_hit) begin
                        bus_req_q <= 1'b0;
                        abort_q   <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StNext: begin
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StReq;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= abort_q;
                    if (!mode_q && !abort_q) begin
                        rd_q <= shadow_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_fields = rd_q;
    assign bus_req   = bus_req_q;
    assign bus_wr    = bus_wr_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_rtc_field_sequencer.sv
// Bench for rtc_field_sequencer: sweep-level timing model plus directed and random sweeps.
module tb_rtc_field_sequencer;

    localparam int N = 3;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, mode, bus_ack;
    logic [23:0] wr_fields, rd_fields;
    logic        busy, done, err, bus_req, bus_wr;
    logic [7:0]  bus_addr, bus_wdata, bus_rdata;

    logic        start1, mode1, ack1;
    logic [7:0]  wr1, rd1, addr1, wdata1, rdata1;
    logic        busy1, done1, err1, req1, bwr1;

    always #5 clk = ~clk;

    rtc_field_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .wr_fields(wr_fields),
        .busy(busy), .done(done), .err(err), .rd_fields(rd_fields),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    rtc_field_sequencer #(.N_FIELDS(1), .ADDR_LIST(8'h40), .TIMEOUT_CYC(3)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode1), .wr_fields(wr1),
        .busy(busy1), .done(done1), .err(err1), .rd_fields(rd1),
        .bus_req(req1), .bus_wr(bwr1), .bus_addr(addr1), .bus_wdata(wdata1),
        .bus_ack(ack1), .bus_rdata(rdata1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sweep plan: the whole waveform of a sweep follows from its start cycle and ack delays.
    int          cyc = 0;
    bit          act = 0;
    int          t0 = 0, done_c = 0, last_f = 0;
    bit          m_mode = 0, aborted = 0;
    logic [23:0] m_wr = '0;
    int          s_c[N], len[N];
    bit          ackd[N];
    logic [7:0]  rdv[N];
    logic [7:0]  addr_tbl[N] = '{8'h21, 8'h22, 8'h23};
    bit          use_force = 0;
    int          force_d[N];
    logic [7:0]  force_rd[N];

    bit          exp_busy = 0, exp_done = 0, exp_err = 0, exp_req = 0, exp_wr = 0;
    logic [7:0]  exp_addr = '0, exp_wdata = '0;
    logic [23:0] exp_rd = '0;

    bit          chk_en = 0, prev_req = 0, err_at_done = 0;
    int          n_done = 0, last_done_cyc = 0;
    logic [7:0]  addr_q[$], wd_q[$];

    task automatic plan_sweep(input int t, input bit md, input logic [23:0] wr);
        int c, d;
        act = 1; t0 = t; m_mode = md; m_wr = wr; aborted = 0; last_f = N - 1;
        c = t + 2;
        for (int i = 0; i < N; i++) begin
            if (use_force) d = force_d[i];
            else d = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1));
            rdv[i]  = use_force ? force_rd[i] : 8'($urandom);
            s_c[i]  = c;
            ackd[i] = d < TO;
            len[i]  = ackd[i] ? d + 1 : TO;
            if (!ackd[i]) begin
                aborted = 1; last_f = i; done_c = c + TO + 1;
                break;
            end
            c = c + d + 3;
        end
        if (!aborted) done_c = c;
    endtask

    function automatic int req_field(input int c);
        int f = -1;
        if (act) begin
            for (int i = 0; i <= last_f; i++) begin
                if (c >= s_c[i] && c < s_c[i] + len[i]) f = i;
            end
        end
        return f;
    endfunction

    task automatic step(input bit st, input bit md, input logic [23:0] wr, input bit spur);
        int f;
        @(posedge clk);
        #1;
        cyc++;
        start = st; mode = md; wr_fields = wr;
        f = req_field(cyc);
        exp_busy = act && cyc > t0 && cyc < done_c;
        exp_done = act && cyc == done_c;
        exp_req  = f >= 0;
        if (exp_req) begin
            exp_addr = addr_tbl[f]; exp_wr = m_mode; exp_wdata = m_wr[f*8 +: 8];
        end
        if (act && cyc == t0 + 1) exp_err = 0;
        if (exp_done) begin
            exp_err = aborted;
            if (!aborted && !m_mode) for (int i = 0; i < N; i++) exp_rd[i*8 +: 8] = rdv[i];
        end
        bus_ack = 0;
        bus_rdata = 8'($urandom);
        if (exp_req && ackd[f] && cyc == s_c[f] + len[f] - 1) begin
            bus_ack = 1; bus_rdata = rdv[f];
        end else if (spur && !exp_req) begin
            bus_ack = ($urandom_range(0, 3) == 0);
        end
        if (st && (!act || cyc >= done_c)) plan_sweep(cyc, md, wr);
    endtask

    task automatic run_idle();
        for (int k = 0; k < 200 && cyc <= done_c; k++) step(0, 0, 24'h0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("rd_fields", rd_fields, exp_rd);
            chk("bus_req", bus_req, exp_req);
            if (exp_req) begin
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_wr", bus_wr, exp_wr);
                if (exp_wr) chk("bus_wdata", bus_wdata, exp_wdata);
            end
            if (done) begin
                n_done++; last_done_cyc = cyc; err_at_done = err;
            end
            if (bus_req && !prev_req) begin
                addr_q.push_back(bus_addr); wd_q.push_back(bus_wdata);
            end
            prev_req = bus_req;
        end
    end

    task automatic run1(input int dly, input logic [7:0] rd, output int done_at,
                        output bit e, output logic [7:0] rdo, output logic [7:0] a);
        done_at = -1; e = 0; rdo = '0; a = '0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            start1 = (k == 0);
            ack1   = (k == 2 + dly);
            rdata1 = ack1 ? rd : 8'hEE;
            @(negedge clk);
            if (done1) begin done_at = k; e = err1; rdo = rd1; end
            if (req1) a = addr1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, old_done, nd, d1;
        bit e1;
        logic [7:0] r1, a1;

        reset = 1; start = 0; mode = 0; wr_fields = '0; bus_ack = 0; bus_rdata = '0;
        start1 = 0; mode1 = 0; wr1 = 8'h5A; ack1 = 0; rdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_rd", rd_fields, 0);
        chk("rst_addr", bus_addr, 0);
        @(posedge clk);
        #1;
        reset = 0;
        chk_en = 1;

        // Read sweep, ack two cycles after each request.
        use_force = 1;
        force_d = '{2, 2, 2};
        force_rd = '{8'h45, 8'h30, 8'h12};
        addr_q.delete(); n_done = 0;
        step(1, 0, 24'hABCDEF, 0);
        t = cyc;
        run_idle();
        chk("rd_sweep_data", rd_fields, 24'h123045);
        chk("rd_sweep_ndone", n_done, 1);
        chk("rd_sweep_err", err_at_done, 0);
        chk("rd_sweep_done_t", last_done_cyc - t, 17);
        chk("rd_sweep_naddr", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            chk("rd_addr0", addr_q[0], 8'h21);
            chk("rd_addr1", addr_q[1], 8'h22);
            chk("rd_addr2", addr_q[2], 8'h23);
        end

        // Write sweep, immediate ack.
        force_d = '{0, 0, 0};
        addr_q.delete(); wd_q.delete();
        step(1, 1, 24'h091500, 0);
        t = cyc;
        run_idle();
        chk("wr_done_t", last_done_cyc - t, 11);
        chk("wr_rd_kept", rd_fields, 24'h123045);
        chk("wr_nxfer", wd_q.size(), 3);
        if (wd_q.size() == 3) begin
            chk("wr_wdata0", wd_q[0], 8'h00);
            chk("wr_wdata1", wd_q[1], 8'h15);
            chk("wr_wdata2", wd_q[2], 8'h09);
        end

        // Timeout on field 1.
        force_d = '{0, TO, 0};
        addr_q.delete();
        step(1, 0, 24'h0, 0);
        t = cyc;
        run_idle();
        chk("tmo_done_t", last_done_cyc - t, 10);
        chk("tmo_err", err_at_done, 1);
        chk("tmo_rd_kept", rd_fields, 24'h123045);
        chk("tmo_nxfer", addr_q.size(), 2);

        // start held every cycle of a sweep, then one cycle after done.
        force_d = '{1, 1, 1};
        n_done = 0;
        step(1, 0, 24'h0, 0);
        old_done = done_c;
        while (cyc < old_done - 1) step(1, 0, 24'h0, 0);
        step(0, 0, 24'h0, 0);
        step(1, 0, 24'h0, 0);
        chk("hold_ndone", n_done, 1);
        step(0, 0, 24'h0, 0);
        chk("hold_restart_busy", busy, 1);
        run_idle();

        // Reset while waiting on field 1.
        force_d = '{0, 3, 0};
        step(1, 0, 24'h0, 0);
        while (cyc < s_c[1] + 1) step(0, 0, 24'h0, 0);
        nd = n_done;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1; start = 0; bus_ack = 0;
        act = 0; exp_busy = 0; exp_done = 0; exp_req = 0; exp_err = 0; exp_rd = '0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_req", bus_req, 0);
        chk("arst_addr", bus_addr, 0);
        chk("arst_rd", rd_fields, 0);
        step(0, 0, 24'h0, 0);
        reset = 0;
        step(0, 0, 24'h0, 0);
        chk("arst_no_done", n_done, nd);
        force_d = '{0, 0, 0};
        addr_q.delete();
        step(1, 0, 24'h0, 0);
        run_idle();
        chk("arst_first_addr", (addr_q.size() > 0) ? addr_q[0] : 8'hFF, 8'h21);

        // Random sweeps with spurious acks outside transactions.
        use_force = 0;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 4) == 0, 1'($urandom), 24'($urandom), 1);
        end
        run_idle();
        chk_en = 0;

        // Single-field instance, TIMEOUT_CYC = 3.
        run1(0, 8'h37, d1, e1, r1, a1);
        chk("n1_done_t", d1, 5);
        chk("n1_err", e1, 0);
        chk("n1_rd", r1, 8'h37);
        chk("n1_addr", a1, 8'h40);
        run1(2, 8'h58, d1, e1, r1, a1);
        chk("n1_tc_ack_done_t", d1, 7);
        chk("n1_tc_ack_err", e1, 0);
        chk("n1_tc_ack_rd", r1, 8'h58);
        run1(3, 8'h99, d1, e1, r1, a1);
        chk("n1_tmo_done_t", d1, 6);
        chk("n1_tmo_err", e1, 1);
        chk("n1_tmo_rd", r1, 8'h58);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
